// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD responder.
// Holds the controller state encoding, the command code points, the DDRAM
// geometry, and the address helpers used by the top and the DDRAM.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT3A = 3'd0,
        ST_INIT3B = 3'd1,
        ST_INIT3C = 3'd2,
        ST_INIT2  = 3'd3,
        ST_HI     = 3'd4,
        ST_LO     = 3'd5
    } lcd_state_e;

    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_DISP  = 8'h08;
    localparam logic [7:0] CMD_SETDD = 8'h80;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [6:0] LINE2 = 7'h40;

    localparam int unsigned DDRAM_DEPTH = 32;

    // Only columns 0x0..0xF of each line exist; bits [5:4] must be clear.
    function automatic logic addr_valid(input logic [6:0] addr);
        return (addr & 7'h30) == 7'h00;
    endfunction

    // Cursor step after a data write; the two 16-cell lines form one ring.
    function automatic logic [6:0] next_cursor(input logic [6:0] addr, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (addr == 7'h0F) begin
                nxt = LINE2;
            end else if (addr == 7'h4F) begin
                nxt = 7'h00;
            end else begin
                nxt = addr + 7'd1;
            end
        end else begin
            if (addr == 7'h00) begin
                nxt = 7'h4F;
            end else if (addr == LINE2) begin
                nxt = 7'h0F;
            end else begin
                nxt = addr - 7'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32 x 8 display data RAM.
// Ports: clk_i/rst_i (sync, active-high, clears only the read register),
//        we_i/waddr_i/wdata_i write port, raddr_i/rdata_o registered read.
// Addresses use the HD44780 map; cell index = {addr[6], addr[3:0]}.
// A write and a read to the same cell in one cycle returns the new byte.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic [6:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [6:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [DDRAM_DEPTH];
    logic [7:0] rdata_q;
    logic [4:0] widx_s;
    logic [4:0] ridx_s;
    logic       unused_addr_bits_s;

    assign widx_s = {waddr_i[6], waddr_i[3:0]};
    assign ridx_s = {raddr_i[6], raddr_i[3:0]};
    // Bits [5:4] do not select storage.
    assign unused_addr_bits_s = ^{waddr_i[5:4], raddr_i[5:4]};

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_s] <= wdata_i;
        end
    end

    // Registered read port with write-through on address collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= 8'h00;
        end else if (we_i && (widx_s == ridx_s)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[ridx_s];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_responder.sv
// Emulates the LCD side of a 4-bit HD44780 bus.
// Inputs : clk, rst (sync, active-high), sf_e/e/rs/rw strobes, nibble {d,c,b,a},
//          rd_addr DDRAM inspection address.
// Outputs: rd_char (1-cycle latency), cmd_valid/cmd_byte, data_valid/data_byte
//          pulses, cursor, display_on, init_done, busy, sticky err_rs/err_busy/err_addr.
// A strobe is the falling edge of e while sf_e=1 and rw=0. After reset, and on
// the clear command, the RAM is blanked over 32 cycles with busy high.
module lcd_responder
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sf_e,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic       d,
    input  logic       c,
    input  logic       b,
    input  logic       a,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       data_valid,
    output logic [7:0] data_byte,
    output logic [6:0] cursor,
    output logic       display_on,
    output logic       init_done,
    output logic       busy,
    output logic       err_rs,
    output logic       err_busy,
    output logic       err_addr
);

    localparam logic [4:0] CLR_LAST = 5'(DDRAM_DEPTH - 1);

    lcd_state_e state_q, state_d;
    logic       e_q;
    logic [3:0] hi_nib_q, hi_nib_d;
    logic       hi_rs_q, hi_rs_d;
    logic [6:0] cursor_q, cursor_d;
    logic       inc_q, inc_d;
    logic       disp_q, disp_d;
    logic       init_done_q, init_done_d;
    logic       clr_q, clr_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic       data_valid_q, data_valid_d;
    logic [7:0] data_byte_q, data_byte_d;
    logic       err_rs_q, err_rs_d;
    logic       err_busy_q, err_busy_d;
    logic       err_addr_q, err_addr_d;

    logic       strobe_s;
    logic [3:0] nib_s;
    logic [7:0] byte_s;
    logic       we_s;
    logic [6:0] waddr_s;
    logic [7:0] wdata_s;

    assign strobe_s = e_q && !e && sf_e && !rw;
    assign nib_s    = {d, c, b, a};
    assign byte_s   = {hi_nib_q, nib_s};

    // Next-state: blanking sequencer, init handshake, nibble pairing, command/data decode.
    always_comb begin
        state_d      = state_q;
        hi_nib_d     = hi_nib_q;
        hi_rs_d      = hi_rs_q;
        cursor_d     = cursor_q;
        inc_d        = inc_q;
        disp_d       = disp_q;
        init_done_d  = init_done_q;
        clr_d        = clr_q;
        clr_cnt_d    = clr_cnt_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        data_valid_d = 1'b0;
        data_byte_d  = data_byte_q;
        err_rs_d     = err_rs_q;
        err_busy_d   = err_busy_q;
        err_addr_d   = err_addr_q;
        we_s         = 1'b0;
        waddr_s      = cursor_q;
        wdata_s      = BLANK;

        if (clr_q) begin
            // Walk cells 0x00..0x0F then 0x40..0x4F.
            we_s      = 1'b1;
            waddr_s   = {clr_cnt_q[4], 2'b00, clr_cnt_q[3:0]};
            wdata_s   = BLANK;
            clr_cnt_d = clr_cnt_q + 5'd1;
            if (clr_cnt_q == CLR_LAST) begin
                clr_d    = 1'b0;
                cursor_d = 7'h00;
                inc_d    = 1'b1;
            end else begin
                clr_d = 1'b1;
            end
        end else begin
            clr_cnt_d = 5'd0;
        end

        if (strobe_s && clr_q) begin
            err_busy_d = 1'b1;
        end else if (strobe_s) begin
            case (state_q)
                ST_INIT3A: begin
                    if (!rs && (nib_s == 4'h3)) state_d = ST_INIT3B;
                    else                        state_d = state_q;
                end
                ST_INIT3B: begin
                    if (!rs && (nib_s == 4'h3)) state_d = ST_INIT3C;
                    else                        state_d = state_q;
                end
                ST_INIT3C: begin
                    if (!rs && (nib_s == 4'h3)) state_d = ST_INIT2;
                    else                        state_d = state_q;
                end
                ST_INIT2: begin
                    if (!rs && (nib_s == 4'h2)) begin
                        state_d     = ST_HI;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_HI: begin
                    hi_nib_d = nib_s;
                    hi_rs_d  = rs;
                    state_d  = ST_LO;
                end
                ST_LO: begin
                    state_d = ST_HI;
                    if (rs != hi_rs_q) begin
                        err_rs_d = 1'b1;
                    end else if (!rs) begin
                        cmd_valid_d = 1'b1;
                        cmd_byte_d  = byte_s;
                        // Highest set bit selects the command.
                        if ((byte_s & CMD_SETDD) != 8'h00) begin
                            cursor_d = byte_s[6:0];
                        end else if (byte_s[7:3] == CMD_DISP[7:3]) begin
                            disp_d = byte_s[2];
                        end else if (byte_s[7:2] == CMD_ENTRY[7:2]) begin
                            inc_d = byte_s[1];
                        end else if (byte_s[7:1] == CMD_HOME[7:1]) begin
                            cursor_d = 7'h00;
                        end else if (byte_s == CMD_CLR) begin
                            clr_d     = 1'b1;
                            clr_cnt_d = 5'd0;
                        end else begin
                            cmd_byte_d = byte_s;
                        end
                    end else if (addr_valid(cursor_q)) begin
                        we_s         = 1'b1;
                        waddr_s      = cursor_q;
                        wdata_s      = byte_s;
                        data_valid_d = 1'b1;
                        data_byte_d  = byte_s;
                        cursor_d     = next_cursor(cursor_q, inc_q);
                    end else begin
                        err_addr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_INIT3A;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; reset also arms the power-on blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT3A;
            e_q          <= 1'b0;
            hi_nib_q     <= 4'h0;
            hi_rs_q      <= 1'b0;
            cursor_q     <= 7'h00;
            inc_q        <= 1'b1;
            disp_q       <= 1'b0;
            init_done_q  <= 1'b0;
            clr_q        <= 1'b1;
            clr_cnt_q    <= 5'd0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= 8'h00;
            data_valid_q <= 1'b0;
            data_byte_q  <= 8'h00;
            err_rs_q     <= 1'b0;
            err_busy_q   <= 1'b0;
            err_addr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_q          <= e;
            hi_nib_q     <= hi_nib_d;
            hi_rs_q      <= hi_rs_d;
            cursor_q     <= cursor_d;
            inc_q        <= inc_d;
            disp_q       <= disp_d;
            init_done_q  <= init_done_d;
            clr_q        <= clr_d;
            clr_cnt_q    <= clr_cnt_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            data_valid_q <= data_valid_d;
            data_byte_q  <= data_byte_d;
            err_rs_q     <= err_rs_d;
            err_busy_q   <= err_busy_d;
            err_addr_q   <= err_addr_d;
        end
    end

    lcd_ddram u_ddram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we_s),
        .waddr_i (waddr_s),
        .wdata_i (wdata_s),
        .raddr_i (rd_addr),
        .rdata_o (rd_char)
    );

    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign data_valid = data_valid_q;
    assign data_byte  = data_byte_q;
    assign cursor     = cursor_q;
    assign display_on = disp_q;
    assign init_done  = init_done_q;
    assign busy       = clr_q;
    assign err_rs     = err_rs_q;
    assign err_busy   = err_busy_q;
    assign err_addr   = err_addr_q;

endmodule
